// File: rtl/sm2tc_conv_sched_if.sv
// Bundle of requester and response handshake signals for the shared
// signed-magnitude to two's-complement conversion scheduler.
interface sm2tc_conv_sched_if #(
  parameter int NREQ  = 4,
  parameter int W     = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 8
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [W-1:0]      rsp_data;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_negz;
  logic              rsp_ready;
  logic [CNT_W-1:0]  conv_cnt;
  logic              busy;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_negz, conv_cnt, busy
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_negz, conv_cnt, busy
  );
endinterface

// File: rtl/sm2tc_conv_sched.sv
// Round-robin scheduler sharing one signed-magnitude to two's-complement
// converter among NREQ requesters, with a saturating completion counter.
module sm2tc_conv_sched #(
  parameter int NREQ  = 4,
  parameter int W     = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 8
) (
  input logic              clk_i,
  input logic              rst_i,
  sm2tc_conv_sched_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [W-1:0]     op_q, op_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [W-1:0]     rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic             rsp_negz_q, rsp_negz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [NREQ-1:0]  req_ready;
  logic [W:0]       conv_res;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= NREQ) sum = sum - NREQ;
    return sum[ID_W-1:0];
  endfunction

  // Returns {negz, result}; a negative zero collapses to plain zero.
  function automatic logic [W:0] convert(input logic [W-1:0] op);
    logic [W-1:0] mag;
    mag = {1'b0, op[W-2:0]};
    if (!op[W-1])
      return {1'b0, op};
    else if (op[W-2:0] == '0)
      return {1'b1, {W{1'b0}}};
    else
      return {1'b0, ~mag + W'(1)};
  endfunction

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && bus.req_valid[wrap_idx(ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_found)
      req_ready[grant_idx] = 1'b1;
  end

  assign conv_res = convert(op_q);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    op_d       = op_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rsp_negz_d = rsp_negz_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          op_d    = bus.req_data[grant_idx*W +: W];
          id_d    = grant_idx;
          state_d = CONV;
        end
      end
      CONV: begin
        rsp_data_d = conv_res[W-1:0];
        rsp_negz_d = conv_res[W];
        rsp_id_d   = id_q;
        state_d    = RESP;
      end
      RESP: begin
        // Next search starts just past the requester that was served.
        if (bus.rsp_ready) begin
          state_d = IDLE;
          ptr_d   = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
          if (cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      op_q       <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rsp_negz_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      op_q       <= op_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rsp_negz_q <= rsp_negz_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_negz  = rsp_negz_q;
  assign bus.conv_cnt  = cnt_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/sm2tc_conv_sched.md
Name: sm2tc_conv_sched

Overview:
Round-robin scheduler that shares one 4-bit signed-magnitude to two's-complement conversion datapath among NREQ requesters. Each requester offers an operand on a valid/ready handshake. The scheduler grants one requester, converts its operand in a registered stage, and presents the tagged result on a single response port with valid/ready back-pressure. It also keeps a saturating count of completed conversions and flags negative-zero inputs.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 4, operand/result width in bits; MSB is the sign (fixed at 4 for this release)
ID_W, 2, requester-index width; must satisfy 2**ID_W >= NREQ
CNT_W, 8, width of the conversion counter

Ports:
CLK  input  1  clock; all state changes on rising edge
RST  input  1  synchronous, active-high reset
REQ_VALID  input  NREQ  per-requester operand valid
REQ_DATA  input  NREQ*W  operands; requester i uses bits [i*W +: W]
REQ_READY  output  NREQ  per-requester accept; at most one bit high
RSP_VALID  output  1  result valid
RSP_DATA  output  W  two's-complement result
RSP_ID  output  ID_W  index of the requester that owns RSP_DATA
RSP_NEGZ  output  1  high with RSP_VALID when the operand was 1000 (negative zero)
RSP_READY  input  1  consumer accepts the result
CONV_CNT  output  CNT_W  completed responses, saturating
BUSY  output  1  high in any state other than IDLE

Behaviour:
- Conversion rule for operand s,m (sign bit, 3-bit magnitude):
  - s=0: result = operand.
  - s=1, m!=0: result = (~{0,m} + 1) truncated to W bits.
  - s=1, m=0: result = 0000, RSP_NEGZ=1.
  - Examples: 0101->0101, 1001->1111, 1011->1101, 1111->1001, 1000->0000.
- FSM states IDLE, CONV, RESP; RST forces IDLE.
- IDLE:
  - Round-robin grant g is the first i with REQ_VALID[i]=1, searching from ptr upward and wrapping modulo NREQ.
  - REQ_READY[g] = 1, driven combinationally from state, ptr and REQ_VALID. All other REQ_READY bits are 0.
  - The transfer occurs on that edge: operand captured into op_reg, g into id_reg, then IDLE->CONV.
  - No valid requester: stay in IDLE, all REQ_READY = 0.
- CONV (one cycle): RSP_DATA, RSP_NEGZ and RSP_ID are registered from op_reg/id_reg; CONV->RESP.
- RESP:
  - RSP_VALID = 1. RSP_DATA, RSP_ID and RSP_NEGZ are held stable until RSP_READY = 1.
  - On an edge with RSP_READY = 1: RESP->IDLE, ptr = (id_reg + 1) mod NREQ, CONV_CNT increments unless at its maximum (2**CNT_W - 1), where it holds.
- Latency: accept at edge t, RSP_VALID high from edge t+2. Minimum accept-to-accept spacing is 3 cycles; there is one outstanding operation at most.
- RSP_READY held high continuously: RESP lasts exactly 1 cycle.
- RSP_READY seen in IDLE or CONV: ignored.
- A requester must hold REQ_VALID and its data stable until its REQ_READY. Deasserting earlier withdraws the request and has no side effect.
- A requester that keeps REQ_VALID high is not granted twice in a row while another requester is valid.
- REQ_DATA changes of non-granted requesters have no effect.
- Reset values: REQ_READY=0, RSP_VALID=0, RSP_DATA=0, RSP_ID=0, RSP_NEGZ=0, CONV_CNT=0, BUSY=0, ptr=0.
- RST mid-operation (CONV or RESP): the in-flight result is discarded with no response, CONV_CNT is not incremented, and the next IDLE grant starts search at 0.
- RST has priority over every other event in the same cycle.
- RSP_DATA, RSP_ID and RSP_NEGZ hold their last values in IDLE; consumers qualify them with RSP_VALID.

Test Plan:
- Reset then single request: REQ_VALID=0001, REQ_DATA[3:0]=1011, RSP_READY=1 -> REQ_READY=0001 at t, RSP_VALID at t+2 with RSP_DATA=1101, RSP_ID=0, RSP_NEGZ=0; CONV_CNT=1 after handshake.
- Full table sweep on requester 2: all 16 operands -> outputs match 0000..0111 identity; 1000->0000 with RSP_NEGZ=1; 1001->1111, 1010->1110, 1100->1100, 1111->1001.
- Round-robin fairness: REQ_VALID=1111 held, operands 0001/1001/0110/1110 -> responses in ID order 0,1,2,3,0 with data 0001,1111,0110,1010; no two consecutive grants to one ID.
- Back-pressure: RSP_READY=0 for 5 cycles in RESP -> RSP_VALID, RSP_DATA, RSP_ID stable, all REQ_READY=0, CONV_CNT unchanged; RSP_READY=1 -> return to IDLE next edge.
- Reset mid-op: assert RST during CONV, then during RESP -> RSP_VALID=0 next cycle, CONV_CNT unchanged, BUSY=0; subsequent REQ_VALID=1010 grants requester 1 first.
- Counter saturation (CNT_W=2 build): 5 completed conversions -> CONV_CNT sequence 1,2,3,3,3.
